mips_state_controller: RTL and testbench

Multicycle sequencer for the MIPS core. Generates the 2-bit `state` consumed by the instruction decoder: FETCH=00, EXEC1=01, EXEC2=10, HALT=11. Holds the current state while the memory bus asserts `waitrequest`, and takes the core to HALT on a halt request or on a bus timeout. Also maintains the `active` flag and the cycle and retired-instruction counters for the top-level CPU.

---
 rtl/mips_state_controller.sv | 133 +++++++++++++
 tb/tb_mips_state_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_state_controller.sv
// mips_state_controller
// Multicycle sequencer for the MIPS core. Produces the decoder state
// (FETCH/EXEC1/EXEC2/HALT) and holds it while the memory bus stalls. A stall
// watchdog sends the core to HALT with a sticky bus_error. The block also keeps
// the active flag and saturating cycle and retired-instruction counters.
//
// Ports
//   clk          core clock, rising edge
//   reset_n      asynchronous active-low reset
//   halt         decoder halt request, sampled in FETCH
//   extra        instruction needs EXEC2, sampled in EXEC1
//   mem_read     decoder MemRead for the current state
//   mem_write    decoder MemWrite for the current state
//   waitrequest  memory bus stall
//   state        current state (FETCH=00 EXEC1=01 EXEC2=10 HALT=11)
//   active       high until the core halts
//   stall        combinational; freezes PC and register-file writes this cycle
//   bus_error    sticky watchdog flag
//   cycle_count  cycles counted while active
//   instr_count  retired instructions
//
// state | meaning
// FETCH | instruction fetch; halt request honoured here
// EXEC1 | first execute cycle; extra selects EXEC2
// EXEC2 | second execute cycle (load/store)
// HALT  | absorbing; only reset leaves it
module mips_state_controller #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             halt,
   input  logic             extra,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             waitrequest,
   output logic [1:0]       state,
   output logic             active,
   output logic             stall,
   output logic             bus_error,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_EXEC1 = 2'b01,
      S_EXEC2 = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   // Terminal count of the stall counter; unused when the watchdog is disabled.
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   state_t          state_q;
   state_t          state_d;
   logic [TO_W-1:0] stall_cnt;
   logic            mem_access;
   logic            timeout_hit;
   logic            retire;

   assign state = state_q;

   always_comb begin
      mem_access  = (mem_read | mem_write) & (state_q != S_HALT);
      stall       = mem_access & waitrequest;
      timeout_hit = (TIMEOUT > 0) && stall && (stall_cnt == TO_LAST);
      retire      = 1'b0;
      state_d     = state_q;

      case (state_q)
         S_FETCH: begin
            if (halt)
               state_d = S_HALT;
            else if (!stall)
               state_d = S_EXEC1;
         end
         S_EXEC1: begin
            if (!stall) begin
               if (extra) begin
                  state_d = S_EXEC2;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         S_EXEC2: begin
            if (!stall) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         default: state_d = S_HALT;
      endcase

      // The watchdog only fires on a stalled cycle, so it never races a retire.
      if (timeout_hit)
         state_d = S_HALT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_FETCH;
         active      <= 1'b1;
         bus_error   <= 1'b0;
         stall_cnt   <= '0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         // HALT is absorbing, so active can follow the next state directly.
         active  <= (state_d != S_HALT);

         if (timeout_hit)
            bus_error <= 1'b1;

         if (!stall)
            stall_cnt <= '0;
         else if (stall_cnt != '1)
            stall_cnt <= stall_cnt + TO_W'(1);

         if (active && (cycle_count != '1))
            cycle_count <= cycle_count + CNT_W'(1);

         if (retire && active && (instr_count != '1))
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_state_controller.sv
module tb_mips_state_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, halt, extra, mem_read, mem_write, waitrequest;

   logic [1:0]  a_state, b_state, c_state;
   logic        a_active, b_active, c_active;
   logic        a_stall, b_stall, c_stall;
   logic        a_bus_error, b_bus_error, c_bus_error;
   logic [31:0] a_cyc, a_ins, c_cyc, c_ins;
   logic [3:0]  b_cyc, b_ins;

   int checks   = 0;
   int failures = 0;

   // Default build: 32-bit counters, watchdog at 255.
   mips_state_controller dut_a (
      .clk(clk), .reset_n(reset_n), .halt(halt), .extra(extra),
      .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
      .state(a_state), .active(a_active), .stall(a_stall), .bus_error(a_bus_error),
      .cycle_count(a_cyc), .instr_count(a_ins)
   );

   // Narrow counters for saturation, watchdog at 4.
   mips_state_controller #(.CNT_W(4), .TIMEOUT(4), .TO_W(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .halt(halt), .extra(extra),
      .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
      .state(b_state), .active(b_active), .stall(b_stall), .bus_error(b_bus_error),
      .cycle_count(b_cyc), .instr_count(b_ins)
   );

   // Watchdog at 1: halts on the first stalled cycle.
   mips_state_controller #(.CNT_W(32), .TIMEOUT(1), .TO_W(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .halt(halt), .extra(extra),
      .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
      .state(c_state), .active(c_active), .stall(c_stall), .bus_error(c_bus_error),
      .cycle_count(c_cyc), .instr_count(c_ins)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic h, input logic e, input logic mr, input logic mw,
                      input logic wr);
      halt        = h;
      extra       = e;
      mem_read    = mr;
      mem_write   = mw;
      waitrequest = wr;
   endtask

   // Reset is released just after a rising edge, so the first step sees no edge.
   task automatic do_reset();
      reset_n = 1'b0;
      drv(0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // One cycle: drive on the falling edge, sample 1 time unit later.
   task automatic step(input logic h, input logic e, input logic mr, input logic mw,
                       input logic wr, input int exp_st);
      @(negedge clk);
      drv(h, e, mr, mw, wr);
      #1;
      chk("a_state", 32'(a_state), exp_st);
   endtask

   initial begin
      reset_n = 1'b0;
      drv(0, 0, 0, 0, 0);

      // 1: reset values and three unstalled two-cycle instructions
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      chk("reset_active", 32'(a_active), 1);
      chk("reset_cyc", a_cyc, 0);
      chk("reset_ins", a_ins, 0);
      chk("reset_bus_error", 32'(a_bus_error), 0);
      chk("reset_b_cyc", 32'(b_cyc), 0);
      for (int i = 1; i <= 6; i++)
         step(0, 0, 0, 0, 0, i % 2);
      chk("t1_cyc", a_cyc, 6);
      chk("t1_ins", a_ins, 3);

      // 2: load through EXEC2 with two waitrequest cycles
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      chk("t2_stall_exec1", 32'(a_stall), 0);
      step(0, 0, 1, 0, 1, 2);
      chk("t2_stall_w1", 32'(a_stall), 1);
      step(0, 0, 1, 0, 1, 2);
      chk("t2_stall_w2", 32'(a_stall), 1);
      chk("c_to1_state", 32'(c_state), 3);
      chk("c_to1_bus_error", 32'(c_bus_error), 1);
      chk("c_halt_stall", 32'(c_stall), 0);
      step(0, 0, 1, 0, 0, 2);
      chk("t2_stall_release", 32'(a_stall), 0);

      // 3: halt in FETCH wins over waitrequest; counters freeze
      step(1, 0, 1, 0, 1, 0);
      chk("t2_ins", a_ins, 1);
      chk("t3_cyc_pre", a_cyc, 5);
      step(1, 0, 1, 0, 1, 3);
      chk("t3_active", 32'(a_active), 0);
      chk("t3_stall", 32'(a_stall), 0);
      chk("t3_cyc", a_cyc, 6);
      chk("t3_b_state", 32'(b_state), 3);
      chk("t3_b_bus_error", 32'(b_bus_error), 0);
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, 1, 1, 3);
      chk("t3_cyc_frozen", a_cyc, 6);
      chk("t3_ins_frozen", a_ins, 1);
      chk("t3_b_cyc_frozen", 32'(b_cyc), 6);
      chk("t3_stall_frozen", 32'(a_stall), 0);

      // 4a: watchdog at 4 with waitrequest held in EXEC1
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 1, 1);
         chk("t4_b_state_stall", 32'(b_state), 1);
      end
      step(0, 0, 1, 0, 1, 1);
      chk("t4_b_state_to", 32'(b_state), 3);
      chk("t4_b_bus_error", 32'(b_bus_error), 1);
      chk("t4_b_active", 32'(b_active), 0);
      chk("t4_a_bus_error", 32'(a_bus_error), 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t4_b_sticky", 32'(b_bus_error), 1);
      chk("t4_a_ins", a_ins, 1);

      // 4b: three stalls then release; counter clears between bursts
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0);
      chk("t4_wr_no_access", 32'(b_stall), 0);
      chk("t4b_bus_error", 32'(b_bus_error), 0);
      chk("t4b_ins", 32'(b_ins), 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 1, 1);
         chk("t4b_b_state_stall", 32'(b_state), 1);
      end
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t4b_b_state", 32'(b_state), 0);
      chk("t4b_bus_error2", 32'(b_bus_error), 0);
      chk("t4b_ins2", 32'(b_ins), 2);

      // 5: asynchronous reset in the middle of EXEC2
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1, 2);
      step(0, 0, 1, 0, 1, 2);
      chk("t5_pre_ins", a_ins, 1);
      chk("t5_pre_cyc", a_cyc, 5);
      chk("t5_pre_c_bus_error", 32'(c_bus_error), 1);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_state", 32'(a_state), 0);
      chk("t5_cyc", a_cyc, 0);
      chk("t5_ins", a_ins, 0);
      chk("t5_c_bus_error", 32'(c_bus_error), 0);
      chk("t5_c_state", 32'(c_state), 0);
      chk("t5_c_active", 32'(c_active), 1);

      // 6: counter saturation on the 4-bit build
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 34; k++) begin
         step(0, 0, 0, 0, 0, k % 2);
         if (k == 14) begin
            chk("t6_b_cyc_14", 32'(b_cyc), 14);
            chk("t6_b_ins_14", 32'(b_ins), 7);
         end
         if (k == 15)
            chk("t6_b_cyc_15", 32'(b_cyc), 15);
         if (k == 16) begin
            chk("t6_b_cyc_sat", 32'(b_cyc), 15);
            chk("t6_b_ins_16", 32'(b_ins), 8);
         end
         if (k == 30)
            chk("t6_b_ins_30", 32'(b_ins), 15);
      end
      chk("t6_b_ins_sat", 32'(b_ins), 15);
      chk("t6_b_cyc_end", 32'(b_cyc), 15);
      chk("t6_b_state", 32'(b_state), 0);
      chk("t6_a_cyc", a_cyc, 34);
      chk("t6_a_ins", a_ins, 17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
